// File: rtl/bitonic_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : bitonic_loader_if
//  Purpose  : Bundles the upstream record stream and the parallel batch
//             output of bitonic_loader.
//  Ports    : master - upstream source / network side (drives s_valid,
//                      s_data, s_last; observes everything else)
//             slave  - the loader itself
//  Revision : 1.0 - initial release
// ============================================================================
interface bitonic_loader_if #(
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 32,
    parameter int N           = 8
);
    localparam int W    = KEY_WIDTH + VALUE_WIDTH + 1;
    localparam int BC_W = $clog2(N) + 1;

    logic                               s_valid;
    logic                               s_ready;
    logic [KEY_WIDTH+VALUE_WIDTH-1:0]   s_data;
    logic                               s_last;
    logic [N*W-1:0]                     net_data;
    logic                               net_start;
    logic [BC_W-1:0]                    batch_count;
    logic                               busy;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, net_data, net_start, batch_count, busy
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, net_data, net_start, batch_count, busy
    );
endinterface
`default_nettype wire

// File: rtl/bitonic_loader.sv
`default_nettype none
// ============================================================================
//  Module   : bitonic_loader
//  Purpose  : Collects up to N {key,value} records from a valid/ready stream
//             into a parallel batch, pads short batches with max-key invalid
//             records, then strobes net_start for SORT_LATENCY cycles
//             followed by one idle RELEASE cycle.
//  Ports    : clk         - clock, rising edge
//             rst         - synchronous active-high reset
//             bus (slave) - s_valid/s_ready/s_data/s_last stream in,
//                           net_data/net_start/batch_count/busy out
//  Revision : 1.0 - initial release
// ============================================================================
module bitonic_loader #(
    parameter int KEY_WIDTH    = 32,
    parameter int VALUE_WIDTH  = 32,
    parameter int N            = 8,
    parameter int SORT_LATENCY = 6
) (
    input  wire logic        clk,
    input  wire logic        rst,
    bitonic_loader_if.slave  bus
);
    localparam int W     = KEY_WIDTH + VALUE_WIDTH + 1;
    localparam int PTR_W = $clog2(N);
    localparam int BC_W  = $clog2(N) + 1;
    localparam int CNT_W = $clog2(SORT_LATENCY + 1);

    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(N - 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SORT_LATENCY - 1);

    // Pad record: invalid, maximum key so an ascending network sinks it.
    localparam logic [W-1:0] PAD_REC = {1'b0, {KEY_WIDTH{1'b1}}, {VALUE_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        PAD     = 2'd1,
        START   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [BC_W-1:0]    batch_count_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               net_start_q;
    logic [W-1:0]       slot_q [N];

    logic               accept;

    assign bus.s_ready     = (state_q == FILL) && !rst;
    assign accept          = bus.s_valid && bus.s_ready;
    assign bus.net_start   = net_start_q;
    assign bus.batch_count = batch_count_q;
    assign bus.busy        = (state_q != FILL) || (wr_ptr_q != '0);

    for (genvar gi = 0; gi < N; gi++) begin : g_slot
        assign bus.net_data[gi*W +: W] = slot_q[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILL;
            wr_ptr_q      <= '0;
            batch_count_q <= '0;
            cnt_q         <= '0;
            net_start_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        slot_q[wr_ptr_q] <= {1'b1, bus.s_data};
                        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
                        batch_count_q    <= batch_count_q + BC_W'(1);
                        // A full batch needs no padding, even with s_last.
                        if (wr_ptr_q == LAST_SLOT) begin
                            state_q     <= START;
                            net_start_q <= 1'b1;
                            cnt_q       <= '0;
                        end else if (bus.s_last) begin
                            state_q <= PAD;
                        end
                    end
                end
                PAD: begin
                    slot_q[wr_ptr_q] <= PAD_REC;
                    wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
                    if (wr_ptr_q == LAST_SLOT) begin
                        state_q     <= START;
                        net_start_q <= 1'b1;
                        cnt_q       <= '0;
                    end
                end
                START: begin
                    if (cnt_q == LAST_CNT) begin
                        state_q     <= RELEASE;
                        net_start_q <= 1'b0;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    // net_start low here lets the network drop its started flag.
                    wr_ptr_q      <= '0;
                    batch_count_q <= '0;
                    state_q       <= FILL;
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bitonic_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitonic_loader
//  Purpose  : Directed self-checking bench for bitonic_loader with N=4,
//             8-bit keys and values, SORT_LATENCY=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bitonic_loader;
    localparam int KW = 8;
    localparam int VW = 8;
    localparam int NN = 4;
    localparam int SL = 3;
    localparam int WW = KW + VW + 1;

    localparam logic [WW-1:0] PADR = 17'h0FF00;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    bitonic_loader_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .N(NN)) bus ();

    bitonic_loader #(
        .KEY_WIDTH   (KW),
        .VALUE_WIDTH (VW),
        .N           (NN),
        .SORT_LATENCY(SL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WW-1:0] rec(input logic [7:0] k, input logic [7:0] v);
        return {1'b1, k, v};
    endfunction

    function automatic logic [NN*WW-1:0] pack4(input logic [WW-1:0] s0, input logic [WW-1:0] s1,
                                               input logic [WW-1:0] s2, input logic [WW-1:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    // Present one record and hold it until the handshake edge.
    task automatic send(input logic [7:0] k, input logic [7:0] v, input logic last);
        int n;
        bus.s_valid = 1'b1;
        bus.s_data  = {k, v};
        bus.s_last  = last;
        n = 0;
        while (!bus.s_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("ready_wait", {127'd0, bus.s_ready}, 128'd1);
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    // Count cycles from now until net_start rises.
    task automatic cycles_to_start(output int d);
        d = 0;
        while (!bus.net_start && d < 20) begin
            tick();
            d++;
        end
    endtask

    // Count consecutive cycles with net_start high.
    task automatic start_len(output int hi);
        hi = 0;
        while (bus.net_start && hi < 20) begin
            tick();
            hi++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bus.s_ready && n < 50) begin
            tick();
            n++;
        end
        check("idle_wait", {127'd0, bus.s_ready}, 128'd1);
    endtask

    logic [NN*WW-1:0] exp_nd;
    int               d;
    int               hi;
    logic             ns_seen;
    logic             nd_moved;
    logic             rdy_seen;

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_ready",  {127'd0, bus.s_ready}, 128'd0);
        check("rst_data",   {60'd0, bus.net_data}, 128'd0);
        check("rst_start",  {127'd0, bus.net_start}, 128'd0);
        check("rst_count",  {125'd0, bus.batch_count}, 128'd0);
        check("rst_busy",   {127'd0, bus.busy}, 128'd0);
        rst = 1'b0;
        #1;
        check("rel_ready",  {127'd0, bus.s_ready}, 128'd1);

        // ---------------- full batch ----------------
        send(8'h05, 8'hA0, 1'b0);
        send(8'h03, 8'hA1, 1'b0);
        send(8'h09, 8'hA2, 1'b0);
        send(8'h01, 8'hA3, 1'b1);
        exp_nd = pack4(rec(8'h05, 8'hA0), rec(8'h03, 8'hA1), rec(8'h09, 8'hA2), rec(8'h01, 8'hA3));
        check("full_start_t1", {127'd0, bus.net_start}, 128'd1);
        check("full_data",     {60'd0, bus.net_data}, {60'd0, exp_nd});
        check("full_count",    {125'd0, bus.batch_count}, 128'd4);
        start_len(hi);
        check("full_start_len", hi, 3);
        check("full_rel_ready", {127'd0, bus.s_ready}, 128'd0);
        check("full_rel_busy",  {127'd0, bus.busy}, 128'd1);
        check("full_rel_data",  {60'd0, bus.net_data}, {60'd0, exp_nd});
        tick();
        check("full_fill_ready", {127'd0, bus.s_ready}, 128'd1);
        check("full_fill_busy",  {127'd0, bus.busy}, 128'd0);
        check("full_fill_count", {125'd0, bus.batch_count}, 128'd0);

        // ---------------- short batch ----------------
        send(8'h07, 8'hB0, 1'b0);
        send(8'h02, 8'hB1, 1'b1);
        check("short_pad_ready", {127'd0, bus.s_ready}, 128'd0);
        cycles_to_start(d);
        check("short_pad_cycles", d, 2);
        exp_nd = pack4(rec(8'h07, 8'hB0), rec(8'h02, 8'hB1), PADR, PADR);
        check("short_data",  {60'd0, bus.net_data}, {60'd0, exp_nd});
        check("short_count", {125'd0, bus.batch_count}, 128'd2);
        wait_idle();

        // ---------------- single record ----------------
        send(8'h42, 8'hC0, 1'b1);
        cycles_to_start(d);
        check("single_pad_cycles", d, 3);
        exp_nd = pack4(rec(8'h42, 8'hC0), PADR, PADR, PADR);
        check("single_data",  {60'd0, bus.net_data}, {60'd0, exp_nd});
        check("single_count", {125'd0, bus.batch_count}, 128'd1);
        wait_idle();

        // ---------------- backpressure through START/RELEASE ----------------
        send(8'h10, 8'hD0, 1'b0);
        send(8'h20, 8'hD1, 1'b0);
        send(8'h30, 8'hD2, 1'b0);
        send(8'h40, 8'hD3, 1'b0);
        exp_nd = pack4(rec(8'h10, 8'hD0), rec(8'h20, 8'hD1), rec(8'h30, 8'hD2), rec(8'h40, 8'hD3));
        bus.s_valid = 1'b1;
        bus.s_data  = {8'hEE, 8'hE0};
        rdy_seen = 1'b0;
        nd_moved = 1'b0;
        for (int i = 0; i < SL + 1; i++) begin
            rdy_seen = rdy_seen | bus.s_ready;
            nd_moved = nd_moved | (bus.net_data !== exp_nd);
            tick();
        end
        check("bp_no_ready", {127'd0, rdy_seen}, 128'd0);
        check("bp_data_held", {127'd0, nd_moved}, 128'd0);
        check("bp_first_fill", {127'd0, bus.s_ready}, 128'd1);
        tick();
        bus.s_valid = 1'b0;
        check("bp_accept_count", {125'd0, bus.batch_count}, 128'd1);
        check("bp_slot0", {111'd0, bus.net_data[WW-1:0]}, {111'd0, rec(8'hEE, 8'hE0)});

        // ---------------- reset mid-PAD ----------------
        send(8'h55, 8'hE1, 1'b1);
        check("pad_before_rst", {127'd0, bus.s_ready}, 128'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ns_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ns_seen = ns_seen | bus.net_start;
            tick();
        end
        check("midrst_start", {127'd0, ns_seen}, 128'd0);
        check("midrst_data",  {60'd0, bus.net_data}, 128'd0);
        check("midrst_count", {125'd0, bus.batch_count}, 128'd0);
        check("midrst_busy",  {127'd0, bus.busy}, 128'd0);
        check("midrst_ready", {127'd0, bus.s_ready}, 128'd1);

        // ---------------- bubbles ----------------
        bus.s_valid = 1'b1; bus.s_data = {8'h61, 8'hF0}; tick();
        bus.s_valid = 1'b0; bus.s_data = {8'h99, 8'h99}; tick();
        bus.s_valid = 1'b1; bus.s_data = {8'h62, 8'hF1}; tick();
        bus.s_valid = 1'b0; bus.s_data = {8'h98, 8'h98}; tick();
        check("bub_count2", {125'd0, bus.batch_count}, 128'd2);
        bus.s_valid = 1'b1; bus.s_data = {8'h63, 8'hF2}; tick();
        bus.s_valid = 1'b0; bus.s_data = {8'h97, 8'h97}; tick();
        bus.s_valid = 1'b1; bus.s_data = {8'h64, 8'hF3}; bus.s_last = 1'b1; tick();
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        exp_nd = pack4(rec(8'h61, 8'hF0), rec(8'h62, 8'hF1), rec(8'h63, 8'hF2), rec(8'h64, 8'hF3));
        check("bub_start", {127'd0, bus.net_start}, 128'd1);
        check("bub_data",  {60'd0, bus.net_data}, {60'd0, exp_nd});
        check("bub_count4", {125'd0, bus.batch_count}, 128'd4);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
